ref_fetch_addr_gen: RTL and testbench
=====================================

REF_FETCH_ADDR_GEN -- requirements
Module: ref_fetch_addr_gen

Interface
REQ-001 SHALL have parameter FRAME_W, default 16'd1920: frame width in samples, used only for clamping.
REQ-002 SHALL have parameter FRAME_H, default 16'd1080: frame height in samples, used only for clamping.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_ASYNC  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port IN_VALID  input  1  generated-MV job offered.
REQ-006 SHALL have port IN_READY  output  1  job accepted when IN_VALID and IN_READY are both high at a rising edge.
REQ-007 SHALL have ports BLK_X and BLK_Y  input  8 each  signed 4x4 sub-block coordinates.
REQ-008 SHALL have ports MV_X_INT and MV_Y_INT  input  15 each  signed integer MV parts.
REQ-009 SHALL have ports MV_X_FRAC and MV_Y_FRAC  input  4 each  1/16 fractional MV parts.
REQ-010 SHALL have ports INTERP_X and INTERP_Y  input  1 each  8-tap interpolation needed per axis.
REQ-011 SHALL have ports ADDR_X and ADDR_Y  output  16 each  signed reference-sample address.
REQ-012 SHALL have port ADDR_VALID  output  1  address beat valid.
REQ-013 SHALL have port ADDR_READY  input  1  consumer accepts the beat.
REQ-014 SHALL have port ADDR_LAST  output  1  marks the final beat of a job.
REQ-015 SHALL have ports FRAC_X_OUT and FRAC_Y_OUT  output  4 each  captured fractions, held for the whole job.

Function
REQ-016 SHALL implement FSM IDLE/FETCH; IN_READY = 1 only in IDLE; ADDR_VALID = 1 only in FETCH.
REQ-017 On IN_VALID and IN_READY in IDLE: capture all inputs, go FETCH next cycle, first beat valid in that cycle (1-cycle latency).
REQ-018 Base addresses: BX = BLK_X*4 + MV_X_INT - (INTERP_X ? 3 : 0); BY = BLK_Y*4 + MV_Y_INT - (INTERP_Y ? 3 : 0).
REQ-019 Arithmetic SHALL be in 17-bit signed; result truncated to 16-bit signed (range fits by construction).
REQ-020 Window size W = INTERP_X ? 11 : 4, H = INTERP_Y ? 11 : 4; beat count W*H = 16, 44, 44 or 121.
REQ-021 Beats SHALL be emitted in raster order: ADDR_X = BX + col, ADDR_Y = BY + row; col 0..W-1 inner, row 0..H-1 outer.
REQ-022 Counters SHALL advance only on ADDR_VALID and ADDR_READY; while ADDR_READY = 0, all outputs SHALL hold stable.
REQ-023 ADDR_LAST SHALL be high exactly on beat (col=W-1, row=H-1).
REQ-024 The handshake of that final beat SHALL return the FSM to IDLE, which gives one bubble before the next job.
REQ-025 IN_VALID SHALL be ignored in FETCH; captured values SHALL not change mid-job.
REQ-026 FRAC_X_OUT/FRAC_Y_OUT SHALL update only on job capture.

Reset
REQ-027 RST_ASYNC high SHALL immediately force state IDLE, counters 0, all captured registers 0, and ADDR_VALID, ADDR_LAST, ADDR_X, ADDR_Y, FRAC_X_OUT, FRAC_Y_OUT all 0.
REQ-028 IN_READY SHALL be 0 while RST_ASYNC is high and 1 from the first cycle after deassertion.
REQ-029 Reset mid-job SHALL abort the job; no beat is emitted for it after reset.

Configuration
REQ-030 With macro REF_CLAMP_EN defined, ADDR_X SHALL be clamped to [0, FRAME_W-1] and ADDR_Y to [0, FRAME_H-1] (edge padding); beat count and order are unchanged.
REQ-031 Without REF_CLAMP_EN, ADDR_X/ADDR_Y SHALL be the raw signed values; FRAME_W/FRAME_H are then unused.

Verification
REQ-032 BLK (0,0), MV int (0,0), no interp, ADDR_READY=1 -> 16 beats (0,0),(1,0)..(3,3); ADDR_LAST on beat 16; IN_READY high 1 cycle later.
REQ-033 BLK (2,1), MV (5,-2), INTERP_X=1 only -> 44 beats; X 10..20, Y 2..5; first beat (10,2), last beat (20,5) with ADDR_LAST.
REQ-034 BLK (1,1), MV (0,0), both interp -> 121 beats; first beat (1,1), last beat (11,11); FRAC outputs equal the captured inputs throughout.
REQ-035 Scenario REQ-033 with ADDR_READY random 50% -> identical 44-beat sequence; no skipped or duplicated beat; outputs stable during stalls.
REQ-036 BLK (0,0), MV (-10,-10), both interp -> first beat (0,0) with REF_CLAMP_EN, (-13,-13) without.
REQ-037 Assert RST_ASYNC at beat 7 of a 16-beat job -> ADDR_VALID 0 in the same cycle; IN_READY 1 the first cycle after release; the next job starts cleanly from beat 1.

Source files
------------

// File: rtl/ref_fetch_addr_gen_if.sv
// ref_fetch_addr_gen_if
//   Bundles the job-input handshake and the address-beat output handshake of
//   the reference fetch address generator.
//   Job side    : IN_VALID/IN_READY, BLK_X/Y, MV_X/Y_INT, MV_X/Y_FRAC, INTERP_X/Y
//   Address side: ADDR_X/Y, ADDR_VALID/ADDR_READY, ADDR_LAST, FRAC_X/Y_OUT
//   modport master : job producer / address consumer (testbench, upstream)
//   modport slave  : the address generator itself
interface ref_fetch_addr_gen_if;
  logic                IN_VALID;
  logic                IN_READY;
  logic signed  [7:0]  BLK_X;
  logic signed  [7:0]  BLK_Y;
  logic signed  [14:0] MV_X_INT;
  logic signed  [14:0] MV_Y_INT;
  logic         [3:0]  MV_X_FRAC;
  logic         [3:0]  MV_Y_FRAC;
  logic                INTERP_X;
  logic                INTERP_Y;
  logic signed  [15:0] ADDR_X;
  logic signed  [15:0] ADDR_Y;
  logic                ADDR_VALID;
  logic                ADDR_READY;
  logic                ADDR_LAST;
  logic         [3:0]  FRAC_X_OUT;
  logic         [3:0]  FRAC_Y_OUT;

  modport master (
    output IN_VALID, BLK_X, BLK_Y, MV_X_INT, MV_Y_INT, MV_X_FRAC, MV_Y_FRAC,
           INTERP_X, INTERP_Y, ADDR_READY,
    input  IN_READY, ADDR_X, ADDR_Y, ADDR_VALID, ADDR_LAST, FRAC_X_OUT, FRAC_Y_OUT
  );

  modport slave (
    input  IN_VALID, BLK_X, BLK_Y, MV_X_INT, MV_Y_INT, MV_X_FRAC, MV_Y_FRAC,
           INTERP_X, INTERP_Y, ADDR_READY,
    output IN_READY, ADDR_X, ADDR_Y, ADDR_VALID, ADDR_LAST, FRAC_X_OUT, FRAC_Y_OUT
  );
endinterface

// File: rtl/ref_fetch_addr_gen.sv
// ref_fetch_addr_gen
//   Turns one motion-compensation job (4x4 sub-block position + MV) into a
//   raster stream of reference-sample addresses covering the interpolation
//   window: 4 or 11 columns by 4 or 11 rows depending on INTERP_X/INTERP_Y.
//   Ports:
//     CLK        : clock, all state on rising edge
//     RST_ASYNC  : asynchronous active-high reset
//     bus        : ref_fetch_addr_gen_if.slave (job in, address beats out)
//   Parameters:
//     FRAME_W/FRAME_H : frame size, only used for edge clamping
//   Build option:
//     REF_CLAMP_EN    : when defined, addresses are clamped to the frame
//                       (edge padding); otherwise raw signed addresses.
module ref_fetch_addr_gen #(
  parameter logic [15:0] FRAME_W = 16'd1920,
  parameter logic [15:0] FRAME_H = 16'd1080
) (
  input  logic               CLK,
  input  logic               RST_ASYNC,
  ref_fetch_addr_gen_if.slave bus
);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t             state_q, state_d;
  logic signed [15:0] bx_q, bx_d, by_q, by_d;
  logic               interp_x_q, interp_x_d, interp_y_q, interp_y_d;
  logic        [3:0]  frac_x_q, frac_x_d, frac_y_q, frac_y_d;
  logic        [3:0]  col_q, col_d, row_q, row_d;
  logic        [3:0]  col_max, row_max;
  logic               col_end, row_end;
  logic               in_ready, addr_valid, in_fire, beat_fire;
  logic signed [16:0] bx_full, by_full;
  logic signed [15:0] raw_x, raw_y;

  // Window origin: 4x4 block position in samples plus integer MV, pulled
  // back by 3 when the 8-tap filter needs left/top context. Kept in 17 bits
  // so intermediate sums cannot wrap; the result always fits 16 bits.
  function automatic logic signed [16:0] base_addr(
    input logic signed [7:0]  blk,
    input logic signed [14:0] mv,
    input logic               interp
  );
    logic signed [16:0] b;
    b = $signed({{7{blk[7]}}, blk, 2'b00});
    b = b + $signed({{2{mv[14]}}, mv});
    if (interp) b = b - 17'sd3;
    return b;
  endfunction

  // Edge padding: clamp a signed coordinate into [0, lim-1].
  function automatic logic signed [15:0] clamp(
    input logic signed [15:0] v,
    input logic        [15:0] lim
  );
    logic signed [16:0] hi;
    hi = $signed({1'b0, lim}) - 17'sd1;
    if (v < 16'sd0)                     return 16'sd0;
    else if ($signed(17'(v)) > hi)      return hi[15:0];
    else                                return v;
  endfunction

  assign bx_full = base_addr(bus.BLK_X, bus.MV_X_INT, bus.INTERP_X);
  assign by_full = base_addr(bus.BLK_Y, bus.MV_Y_INT, bus.INTERP_Y);

  assign col_max = interp_x_q ? 4'd10 : 4'd3;
  assign row_max = interp_y_q ? 4'd10 : 4'd3;
  assign col_end = (col_q == col_max);
  assign row_end = (row_q == row_max);

  always_ff @(posedge CLK or posedge RST_ASYNC) begin
    if (RST_ASYNC) begin
      state_q    <= IDLE;
      bx_q       <= '0;
      by_q       <= '0;
      interp_x_q <= 1'b0;
      interp_y_q <= 1'b0;
      frac_x_q   <= '0;
      frac_y_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
    end else begin
      state_q    <= state_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      interp_x_q <= interp_x_d;
      interp_y_q <= interp_y_d;
      frac_x_q   <= frac_x_d;
      frac_y_q   <= frac_y_d;
      col_q      <= col_d;
      row_q      <= row_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bx_d       = bx_q;
    by_d       = by_q;
    interp_x_d = interp_x_q;
    interp_y_d = interp_y_q;
    frac_x_d   = frac_x_q;
    frac_y_d   = frac_y_q;
    col_d      = col_q;
    row_d      = row_q;
    // Reset holds the FSM in IDLE, so ready must also be gated by reset.
    in_ready   = (state_q == IDLE) && !RST_ASYNC;
    addr_valid = (state_q == FETCH);
    in_fire    = in_ready && bus.IN_VALID;
    beat_fire  = addr_valid && bus.ADDR_READY;

    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          bx_d       = bx_full[15:0];
          by_d       = by_full[15:0];
          interp_x_d = bus.INTERP_X;
          interp_y_d = bus.INTERP_Y;
          frac_x_d   = bus.MV_X_FRAC;
          frac_y_d   = bus.MV_Y_FRAC;
          col_d      = '0;
          row_d      = '0;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        if (beat_fire) begin
          if (col_end) begin
            col_d = '0;
            if (row_end) begin
              row_d   = '0;
              state_d = IDLE;
            end else begin
              row_d = row_q + 4'd1;
            end
          end else begin
            col_d = col_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign raw_x = bx_q + $signed({12'd0, col_q});
  assign raw_y = by_q + $signed({12'd0, row_q});

`ifdef REF_CLAMP_EN
  assign bus.ADDR_X = clamp(raw_x, FRAME_W);
  assign bus.ADDR_Y = clamp(raw_y, FRAME_H);
`else
  // Frame dimensions only matter when clamping is built in.
  logic unused_frame_dims;
  assign unused_frame_dims = ^{FRAME_W, FRAME_H};
  assign bus.ADDR_X = raw_x;
  assign bus.ADDR_Y = raw_y;
`endif

  assign bus.IN_READY   = in_ready;
  assign bus.ADDR_VALID = addr_valid;
  assign bus.ADDR_LAST  = addr_valid && col_end && row_end;
  assign bus.FRAC_X_OUT = frac_x_q;
  assign bus.FRAC_Y_OUT = frac_y_q;

endmodule

// File: tb/tb_ref_fetch_addr_gen.sv
// tb_ref_fetch_addr_gen
//   Directed bench for ref_fetch_addr_gen: reset state, the four window
//   shapes, back-pressure, captured-value stability, negative addresses
//   (raw or clamped depending on REF_CLAMP_EN) and a mid-job reset.
module tb_ref_fetch_addr_gen;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

`ifdef REF_CLAMP_EN
  localparam bit CLAMP_ON = 1'b1;
`else
  localparam bit CLAMP_ON = 1'b0;
`endif
  localparam int FW = 1920;
  localparam int FH = 1080;

  ref_fetch_addr_gen_if bus();

  ref_fetch_addr_gen #(.FRAME_W(16'd1920), .FRAME_H(16'd1080)) dut (
    .CLK      (clk),
    .RST_ASYNC(rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int exp_coord(input int v, input int lim);
    if (CLAMP_ON && v < 0)       return 0;
    if (CLAMP_ON && v > lim - 1) return lim - 1;
    return v;
  endfunction

  // Offers one job and follows every beat to completion. exp_bx/exp_by are
  // the hand-computed raw window origins. With noise set, IN_VALID stays
  // high and the job fields change during FETCH; the stream must not care.
  task automatic run_job(input string name,
                         input int blkx, input int blky, input int mvx, input int mvy,
                         input int fx, input int fy, input bit ix, input bit iy,
                         input int exp_bx, input int exp_by,
                         input bit rnd_ready, input bit noise);
    int w, h, n, k, cyc;
    w = ix ? 11 : 4;
    h = iy ? 11 : 4;
    n = w * h;
    k = 0;
    cyc = 0;
    while (bus.IN_READY !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, " in_ready_before_job"}, bus.IN_READY, 1);
    bus.BLK_X     = 8'(blkx);
    bus.BLK_Y     = 8'(blky);
    bus.MV_X_INT  = 15'(mvx);
    bus.MV_Y_INT  = 15'(mvy);
    bus.MV_X_FRAC = 4'(fx);
    bus.MV_Y_FRAC = 4'(fy);
    bus.INTERP_X  = ix;
    bus.INTERP_Y  = iy;
    bus.IN_VALID  = 1'b1;
    @(posedge clk); #1;
    if (noise) begin
      bus.BLK_X     = 8'sd50;
      bus.MV_Y_INT  = 15'sd100;
      bus.MV_X_FRAC = 4'(~fx);
      bus.INTERP_X  = ~ix;
    end else begin
      bus.IN_VALID = 1'b0;
    end
    check({name, " in_ready_low_in_fetch"}, bus.IN_READY, 0);
    cyc = 0;
    while (k < n && cyc < 2000) begin
      bus.ADDR_READY = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (k == n - 1) bus.IN_VALID = 1'b0;
      check($sformatf("%s valid b%0d", name, k), bus.ADDR_VALID, 1);
      check($sformatf("%s addr_x b%0d", name, k), bus.ADDR_X,
            exp_coord(exp_bx + (k % w), FW));
      check($sformatf("%s addr_y b%0d", name, k), bus.ADDR_Y,
            exp_coord(exp_by + (k / w), FH));
      check($sformatf("%s last b%0d", name, k), bus.ADDR_LAST, (k == n - 1) ? 1 : 0);
      check($sformatf("%s frac_x b%0d", name, k), bus.FRAC_X_OUT, fx);
      check($sformatf("%s frac_y b%0d", name, k), bus.FRAC_Y_OUT, fy);
      if (bus.ADDR_READY) k++;
      @(posedge clk); #1;
      cyc++;
    end
    check({name, " beats_completed"}, k, n);
    check({name, " bubble_valid"}, bus.ADDR_VALID, 0);
    check({name, " bubble_in_ready"}, bus.IN_READY, 1);
    bus.ADDR_READY = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.IN_VALID   = 1'b0;
    bus.ADDR_READY = 1'b0;
    bus.BLK_X      = '0;
    bus.BLK_Y      = '0;
    bus.MV_X_INT   = '0;
    bus.MV_Y_INT   = '0;
    bus.MV_X_FRAC  = '0;
    bus.MV_Y_FRAC  = '0;
    bus.INTERP_X   = 1'b0;
    bus.INTERP_Y   = 1'b0;
    #2;
    check("rst in_ready", bus.IN_READY, 0);
    check("rst addr_valid", bus.ADDR_VALID, 0);
    check("rst addr_last", bus.ADDR_LAST, 0);
    check("rst addr_x", bus.ADDR_X, 0);
    check("rst addr_y", bus.ADDR_Y, 0);
    check("rst frac_x", bus.FRAC_X_OUT, 0);
    check("rst frac_y", bus.FRAC_Y_OUT, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst in_ready", bus.IN_READY, 1);
    check("post_rst addr_valid", bus.ADDR_VALID, 0);

    // 4x4 window at the origin
    run_job("basic", 0, 0, 0, 0, 5, 9, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    // 11x4 window: BX = 8+5-3 = 10, BY = 4-2 = 2
    run_job("interp_x", 2, 1, 5, -2, 7, 2, 1'b1, 1'b0, 10, 2, 1'b0, 1'b0);
    // 11x11 window with IN_VALID and fields wiggling mid-job: BX = BY = 4-3 = 1
    run_job("both", 1, 1, 0, 0, 12, 3, 1'b1, 1'b1, 1, 1, 1'b0, 1'b1);
    // same as interp_x under random back-pressure
    run_job("stall", 2, 1, 5, -2, 1, 14, 1'b1, 1'b0, 10, 2, 1'b1, 1'b0);
    // negative window: BX = BY = 0-10-3 = -13 (0 when clamped)
    run_job("neg", 0, 0, -10, -10, 0, 8, 1'b1, 1'b1, -13, -13, 1'b0, 1'b0);
    // 4x11 window: BX = -4+3 = -1, BY = 12+0-3 = 9
    run_job("interp_y", -1, 3, 3, 0, 15, 15, 1'b0, 1'b1, -1, 9, 1'b0, 1'b0);

    // Mid-job reset at beat 7 of a 16-beat job
    bus.BLK_X     = 8'sd0;
    bus.BLK_Y     = 8'sd0;
    bus.MV_X_INT  = 15'sd0;
    bus.MV_Y_INT  = 15'sd0;
    bus.MV_X_FRAC = 4'd6;
    bus.MV_Y_FRAC = 4'd10;
    bus.INTERP_X  = 1'b0;
    bus.INTERP_Y  = 1'b0;
    bus.IN_VALID  = 1'b1;
    @(posedge clk); #1;
    bus.IN_VALID   = 1'b0;
    bus.ADDR_READY = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    check("abort beat7 valid", bus.ADDR_VALID, 1);
    check("abort beat7 x", bus.ADDR_X, 2);
    check("abort beat7 y", bus.ADDR_Y, 1);
    rst = 1'b1;
    #1;
    check("abort valid", bus.ADDR_VALID, 0);
    check("abort in_ready", bus.IN_READY, 0);
    check("abort addr_x", bus.ADDR_X, 0);
    check("abort addr_y", bus.ADDR_Y, 0);
    check("abort frac_x", bus.FRAC_X_OUT, 0);
    check("abort last", bus.ADDR_LAST, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("release in_ready", bus.IN_READY, 1);
    check("release valid", bus.ADDR_VALID, 0);
    @(posedge clk); #1;
    check("release idle valid", bus.ADDR_VALID, 0);
    bus.ADDR_READY = 1'b0;
    run_job("after_rst", 0, 0, 0, 0, 4, 11, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
